// File: rtl/regn_array.sv
// regn_array: bank of DEPTH enabled N-bit registers with a single command port
// (NOP, WRITE, SWAP, SHIFT_IN, CLEAR, CSWAP), a registered read port and a
// flat parallel view of all entries.
// Build option: define REGN_ARRAY_SIGNED_EN to make CSWAP compare entries as
// two's-complement signed values (default build compares unsigned).
module regn_array #(
  parameter  int N     = 16,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [2:0]         cmd_op,
  input  logic [AW-1:0]      cmd_idx_a,
  input  logic [AW-1:0]      cmd_idx_b,
  input  logic [N-1:0]       cmd_data,
  input  logic [AW-1:0]      rd_idx,
  output logic [N-1:0]       rd_data,
  output logic [N*DEPTH-1:0] q_flat,
  output logic               done,
  output logic               swapped,
  output logic               err
);

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_WRITE = 3'd1,
    OP_SWAP  = 3'd2,
    OP_SHIFT = 3'd3,
    OP_CLEAR = 3'd4,
    OP_CSWAP = 3'd5
  } op_e;

  typedef enum logic {
    IDLE = 1'b0,
    CLR  = 1'b1
  } state_e;

  // Index bound held one bit wider so DEPTH itself is representable.
  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

  state_e        state;
  logic [AW-1:0] clr_idx;
  logic [N-1:0]  mem [DEPTH];

  op_e           op;
  logic          a_ok;
  logic          b_ok;
  logic          rd_ok;
  logic [N-1:0]  ent_a;
  logic [N-1:0]  ent_b;
  logic          gt;

  assign cmd_ready = (state == IDLE);

  // Decode the command, range-check indices and evaluate the CSWAP compare
  // on the pre-edge entry values.
  always_comb begin
    op    = op_e'(cmd_op);
    a_ok  = ({1'b0, cmd_idx_a} < DEPTH_W);
    b_ok  = ({1'b0, cmd_idx_b} < DEPTH_W);
    rd_ok = ({1'b0, rd_idx} < DEPTH_W);
    ent_a = a_ok ? mem[cmd_idx_a] : '0;
    ent_b = b_ok ? mem[cmd_idx_b] : '0;
`ifdef REGN_ARRAY_SIGNED_EN
    gt    = ($signed(ent_a) > $signed(ent_b));
`else
    gt    = (ent_a > ent_b);
`endif
  end

  // Flatten the entries, entry i at bits [i*N +: N].
  always_comb begin
    q_flat = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      q_flat[i*N +: N] = mem[i];
    end
  end

  // Command FSM, entry storage, registered read port and status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      state   <= IDLE;
      clr_idx <= '0;
      rd_data <= '0;
      done    <= 1'b0;
      swapped <= 1'b0;
      err     <= 1'b0;
    end else begin
      done    <= 1'b0;
      swapped <= 1'b0;
      err     <= 1'b0;
      rd_data <= rd_ok ? mem[rd_idx] : '0;

      case (state)
        IDLE: begin
          if (cmd_valid) begin
            case (op)
              OP_NOP: begin
              end
              OP_WRITE: begin
                if (a_ok) begin
                  mem[cmd_idx_a] <= cmd_data;
                  done           <= 1'b1;
                end else begin
                  err <= 1'b1;
                end
              end
              OP_SWAP: begin
                if (a_ok && b_ok) begin
                  mem[cmd_idx_a] <= ent_b;
                  mem[cmd_idx_b] <= ent_a;
                  done           <= 1'b1;
                end else begin
                  err <= 1'b1;
                end
              end
              OP_SHIFT: begin
                mem[0] <= cmd_data;
                for (int unsigned i = 1; i < DEPTH; i++) begin
                  mem[i] <= mem[i-1];
                end
                done <= 1'b1;
              end
              OP_CLEAR: begin
                state   <= CLR;
                clr_idx <= '0;
              end
              OP_CSWAP: begin
                if (a_ok && b_ok) begin
                  if (gt) begin
                    mem[cmd_idx_a] <= ent_b;
                    mem[cmd_idx_b] <= ent_a;
                    swapped        <= 1'b1;
                  end
                  done <= 1'b1;
                end else begin
                  err <= 1'b1;
                end
              end
              default: begin
                err <= 1'b1;
              end
            endcase
          end
        end
        CLR: begin
          mem[clr_idx] <= '0;
          if (clr_idx == LAST) begin
            state <= IDLE;
            done  <= 1'b1;
          end else begin
            clr_idx <= clr_idx + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regn_array.sv
// Directed testbench for regn_array: a DEPTH=8 instance for the main command
// set and a DEPTH=6 instance for out-of-range indices and mid-CLEAR reset.
module tb_regn_array;

  logic         clk;

  // DEPTH=8 instance
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [2:0]   cmd_op;
  logic [2:0]   idx_a;
  logic [2:0]   idx_b;
  logic [15:0]  data;
  logic [2:0]   rd_idx;
  logic [15:0]  rd_data;
  logic [127:0] q;
  logic         done;
  logic         swapped;
  logic         err;

  // DEPTH=6 instance
  logic         rst6;
  logic         cmd_valid6;
  logic         cmd_ready6;
  logic [2:0]   cmd_op6;
  logic [2:0]   idx_a6;
  logic [2:0]   idx_b6;
  logic [15:0]  data6;
  logic [2:0]   rd_idx6;
  logic [15:0]  rd_data6;
  logic [95:0]  q6;
  logic         done6;
  logic         swapped6;
  logic         err6;

  int unsigned  tests;
  int unsigned  fails;
  logic [127:0] exp_q;
  logic         exp_sw;
  logic [15:0]  exp_e1;
  logic [15:0]  exp_e2;

  regn_array #(.N(16), .DEPTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_idx_a(idx_a),
    .cmd_idx_b(idx_b),
    .cmd_data (data),
    .rd_idx   (rd_idx),
    .rd_data  (rd_data),
    .q_flat   (q),
    .done     (done),
    .swapped  (swapped),
    .err      (err)
  );

  regn_array #(.N(16), .DEPTH(6)) dut6 (
    .clk      (clk),
    .rst      (rst6),
    .cmd_valid(cmd_valid6),
    .cmd_ready(cmd_ready6),
    .cmd_op   (cmd_op6),
    .cmd_idx_a(idx_a6),
    .cmd_idx_b(idx_b6),
    .cmd_data (data6),
    .rd_idx   (rd_idx6),
    .rd_data  (rd_data6),
    .q_flat   (q6),
    .done     (done6),
    .swapped  (swapped6),
    .err      (err6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b,
                       input logic [15:0] d);
    cmd_valid = 1'b1;
    cmd_op    = op;
    idx_a     = a;
    idx_b     = b;
    data      = d;
    tick();
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
  endtask

  task automatic issue6(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b,
                        input logic [15:0] d);
    cmd_valid6 = 1'b1;
    cmd_op6    = op;
    idx_a6     = a;
    idx_b6     = b;
    data6      = d;
    tick();
    cmd_valid6 = 1'b0;
    cmd_op6    = 3'd0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; idx_a = '0; idx_b = '0; data = '0; rd_idx = '0;
    rst6 = 1'b1; cmd_valid6 = 1'b0; cmd_op6 = 3'd0; idx_a6 = '0; idx_b6 = '0; data6 = '0;
    rd_idx6 = '0;

    tick();
    tick();
    check("rst_q", q, '0);
    check("rst_rd", 128'(rd_data), '0);
    check("rst_done", 128'(done), '0);
    check("rst_swapped", 128'(swapped), '0);
    check("rst_err", 128'(err), '0);
    check("rst_ready", 128'(cmd_ready), 128'd1);
    rst = 1'b0;
    tick();
    check("idle_ready", 128'(cmd_ready), 128'd1);

    // SHIFT_IN 5, 3, 9 back to back
    issue(3'd3, 3'd0, 3'd0, 16'd5);
    check("shift1_done", 128'(done), 128'd1);
    issue(3'd3, 3'd0, 3'd0, 16'd3);
    check("shift2_done", 128'(done), 128'd1);
    issue(3'd3, 3'd0, 3'd0, 16'd9);
    check("shift3_done", 128'(done), 128'd1);
    check("shift_q", q, 128'h0005_0003_0009);
    tick();
    check("shift_done_pulse", 128'(done), '0);

    // WRITE then registered read
    issue(3'd1, 3'd3, 3'd0, 16'hBEEF);
    check("write_done", 128'(done), 128'd1);
    check("write_q", q, 128'hBEEF_0005_0003_0009);
    rd_idx = 3'd3;
    tick();
    check("read_beef", 128'(rd_data), 128'hBEEF);
    check("read_done_low", 128'(done), '0);

    // SWAP 3,0 and SWAP with equal indices
    issue(3'd2, 3'd3, 3'd0, 16'd0);
    check("swap_done", 128'(done), 128'd1);
    check("swap_q", q, 128'h0009_0005_0003_BEEF);
    issue(3'd2, 3'd3, 3'd3, 16'd0);
    check("swap_same_done", 128'(done), 128'd1);
    check("swap_same_q", q, 128'h0009_0005_0003_BEEF);

    // NOP: accepted, nothing happens
    issue(3'd0, 3'd1, 3'd2, 16'h1234);
    check("nop_done", 128'(done), '0);
    check("nop_err", 128'(err), '0);
    check("nop_q", q, 128'h0009_0005_0003_BEEF);

    // Reserved op
    issue(3'd7, 3'd1, 3'd2, 16'h1234);
    check("rsv_err", 128'(err), 128'd1);
    check("rsv_done", 128'(done), '0);
    check("rsv_q", q, 128'h0009_0005_0003_BEEF);

    // CSWAP 7 vs 2 swaps, repeat does not
    issue(3'd1, 3'd1, 3'd0, 16'd7);
    issue(3'd1, 3'd2, 3'd0, 16'd2);
    check("cs_setup_q", q, 128'h0009_0002_0007_BEEF);
    issue(3'd5, 3'd1, 3'd2, 16'd0);
    check("cs1_done", 128'(done), 128'd1);
    check("cs1_swapped", 128'(swapped), 128'd1);
    check("cs1_q", q, 128'h0009_0007_0002_BEEF);
    issue(3'd5, 3'd1, 3'd2, 16'd0);
    check("cs2_done", 128'(done), 128'd1);
    check("cs2_swapped", 128'(swapped), '0);
    check("cs2_q", q, 128'h0009_0007_0002_BEEF);

    // CSWAP 0xFFFF vs 1: sign-dependent
    issue(3'd1, 3'd1, 3'd0, 16'hFFFF);
    issue(3'd1, 3'd2, 3'd0, 16'h0001);
`ifdef REGN_ARRAY_SIGNED_EN
    exp_sw = 1'b0; exp_e1 = 16'hFFFF; exp_e2 = 16'h0001;
`else
    exp_sw = 1'b1; exp_e1 = 16'h0001; exp_e2 = 16'hFFFF;
`endif
    issue(3'd5, 3'd1, 3'd2, 16'd0);
    check("cs3_done", 128'(done), 128'd1);
    check("cs3_swapped", 128'(swapped), 128'(exp_sw));
    check("cs3_e1", 128'(q[31:16]), 128'(exp_e1));
    check("cs3_e2", 128'(q[47:32]), 128'(exp_e2));

    // Fill all entries nonzero: entry j = 8-j
    for (int i = 1; i <= 8; i++) begin
      issue(3'd3, 3'd0, 3'd0, 16'(i));
    end
    check("fill_q", q, 128'h0001_0002_0003_0004_0005_0006_0007_0008);

    // CLEAR with a WRITE held on cmd_valid while busy
    cmd_valid = 1'b1;
    cmd_op    = 3'd4;
    tick();
    cmd_op = 3'd1;
    idx_a  = 3'd5;
    data   = 16'hAAAA;
    for (int k = 0; k < 8; k++) begin
      exp_q = '0;
      for (int j = 0; j < 8; j++) begin
        exp_q[j*16 +: 16] = (j < k) ? 16'd0 : 16'(8 - j);
      end
      check("clr_ready", 128'(cmd_ready), '0);
      check("clr_done", 128'(done), '0);
      check("clr_q", q, exp_q);
      tick();
    end
    check("clr_end_ready", 128'(cmd_ready), 128'd1);
    check("clr_end_done", 128'(done), 128'd1);
    check("clr_end_q", q, '0);
    tick();
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    check("held_wr_done", 128'(done), 128'd1);
    check("held_wr_q", q, 128'h0000_0000_AAAA_0000_0000_0000_0000_0000);

    // DEPTH=6 instance: range errors
    rst6 = 1'b0;
    tick();
    check("d6_ready", 128'(cmd_ready6), 128'd1);
    issue6(3'd1, 3'd0, 3'd0, 16'h1111);
    issue6(3'd1, 3'd2, 3'd0, 16'h1234);
    check("d6_wr_done", 128'(done6), 128'd1);
    issue6(3'd1, 3'd7, 3'd0, 16'h5555);
    check("d6_oob_err", 128'(err6), 128'd1);
    check("d6_oob_done", 128'(done6), '0);
    check("d6_oob_q", 128'(q6), 128'h1234_0000_1111);
    tick();
    check("d6_err_pulse", 128'(err6), '0);
    issue6(3'd2, 3'd0, 3'd6, 16'd0);
    check("d6_swap_oob_err", 128'(err6), 128'd1);
    check("d6_swap_oob_q", 128'(q6), 128'h1234_0000_1111);
    rd_idx6 = 3'd7;
    tick();
    check("d6_rd_oob", 128'(rd_data6), '0);
    rd_idx6 = 3'd2;
    tick();
    check("d6_rd2", 128'(rd_data6), 128'h1234);

    // DEPTH=6 instance: reset in the 3rd CLEAR cycle
    cmd_valid6 = 1'b1;
    cmd_op6    = 3'd4;
    tick();
    cmd_valid6 = 1'b0;
    cmd_op6    = 3'd0;
    check("d6_clr_ready", 128'(cmd_ready6), '0);
    tick();
    tick();
    check("d6_clr_partial_q", 128'(q6), 128'h1234_0000_0000);
    rst6 = 1'b1;
    #1;
    check("d6_mrst_q", 128'(q6), '0);
    check("d6_mrst_rd", 128'(rd_data6), '0);
    check("d6_mrst_done", 128'(done6), '0);
    check("d6_mrst_ready", 128'(cmd_ready6), 128'd1);
    tick();
    rst6 = 1'b0;
    #1;
    check("d6_rel_ready", 128'(cmd_ready6), 128'd1);
    tick();
    check("d6_rel_done", 128'(done6), '0);
    check("d6_rel_q", 128'(q6), '0);
    issue6(3'd1, 3'd5, 3'd0, 16'h0042);
    check("d6_post_done", 128'(done6), 128'd1);
    check("d6_post_q", 128'(q6), 128'h0042_0000_0000_0000_0000_0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/regn_array.md
Name: regn_array

Overview:
Parametrised bank of DEPTH enabled registers, each N bits wide. It is the storage and exchange element of the sorter datapath. A single command port loads, shifts, swaps, conditionally swaps (compare-exchange) or clears entries. A registered read port and a flat parallel output feed the sorter control and the result sink.

Parameters:
N, 16, data width of each entry
DEPTH, 8, number of entries (2..256)
AW, $clog2(DEPTH), index width (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept a command
cmd_op  in  3  0 NOP, 1 WRITE, 2 SWAP, 3 SHIFT_IN, 4 CLEAR, 5 CSWAP; 6,7 reserved
cmd_idx_a  in  AW  first entry index
cmd_idx_b  in  AW  second entry index
cmd_data  in  N  write/shift data
rd_idx  in  AW  read index
rd_data  out  N  registered read data
q_flat  out  N*DEPTH  all entries; entry i at bits [i*N +: N]
done  out  1  one-cycle pulse, command completed
swapped  out  1  one-cycle pulse, CSWAP exchanged entries
err  out  1  one-cycle pulse, command rejected

Behaviour:
- Reset: all entries 0, rd_data 0, done/swapped/err 0, FSM IDLE, cmd_ready 1.
- Accept: a command is accepted when cmd_valid && cmd_ready at a rising edge.
- FSM states: IDLE, CLR.
  - IDLE: cmd_ready=1.
  - CLR: cmd_ready=0.
- WRITE: entry[a] <= cmd_data at the accept edge. done pulses on the next cycle.
- SWAP: entry[a] and entry[b] exchange at the accept edge; done next cycle.
  - a==b: no change, done still pulses.
- SHIFT_IN: entry[0] <= cmd_data; entry[i] <= entry[i-1] for i>=1; entry[DEPTH-1] is discarded. done next cycle.
- CSWAP: if entry[a] > entry[b] (unsigned, full N bits), exchange and pulse swapped together with done. Otherwise no change, done only.
  - Compare uses pre-edge values.
- CLEAR: IDLE -> CLR. One entry zeroed per cycle, index 0 up to DEPTH-1, so DEPTH cycles.
  - On the last entry: back to IDLE, done pulses the following cycle, cmd_ready returns to 1 in that same cycle.
  - Entries not yet cleared keep their value and remain visible on q_flat and rd_data.
- NOP: accepted; no state change, no done.
- Reserved op, or any used index >= DEPTH: no state change, err pulses next cycle, done stays 0.
  - WRITE checks a; SWAP and CSWAP check a and b; SHIFT_IN, CLEAR and NOP check none.
- Accept rate: back-to-back commands at one per cycle in IDLE. done/err of command k coincide with acceptance of command k+1.
- rd_data: registered, rd_data <= entry[rd_idx] each cycle, reflecting pre-edge contents (one-cycle latency). rd_idx >= DEPTH reads 0.
- q_flat: combinational from the entry registers (no added latency).
- Mid-operation reset: asserting rst during CLR or any command immediately zeroes everything and returns to IDLE. No done is produced.
- cmd_valid while cmd_ready=0: ignored, not queued. The upstream must hold the command.

Optional Feature:
Macro REGN_ARRAY_SIGNED_EN.
- Defined: CSWAP compares entries as two's-complement signed N-bit values.
- Undefined: unsigned compare.
- All other ops are identical in both builds.

Test Plan:
- Reset, then SHIFT_IN 5,3,9 (N=16, DEPTH=8) -> entry0=9, entry1=3, entry2=5, rest 0; done pulses once per command, one cycle after each accept.
- WRITE idx3=0xBEEF, then rd_idx=3 -> rd_data=0xBEEF one cycle after the write's done; SWAP a=3 b=0 -> entry0=0xBEEF, entry3 old entry0.
- entry1=7, entry2=2, CSWAP a=1 b=2 -> entries 2,7, swapped=1; repeat -> no change, swapped=0, done=1.
- Signed build: entry1=0xFFFF, entry2=1, CSWAP a=1 b=2 -> no swap. Unsigned build -> swap, swapped=1.
- CLEAR with all entries nonzero -> cmd_ready=0 for exactly 8 cycles; cleared entries go to 0 one per cycle from index 0; done follows; a WRITE held on cmd_valid is accepted only after cmd_ready returns.
- DEPTH=6: WRITE idx 7 -> err pulse, no done, contents unchanged. Assert rst in the 3rd CLEAR cycle -> all outputs 0, cmd_ready=1 immediately after release.
